// File: rtl/pipelined_prefix_adder_pkg.sv
// Shared constants and helpers for the pipelined prefix adder.
//  - Default operand width, group size and tag width.
//  - Legal range of pipeline register slices.
//  - 2-bit {g,p} pair encoding used by the prefix tree, plus the
//    associative combine operator applied at every tree node.
package pipelined_prefix_adder_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_GROUP = 4;
  localparam int DEF_TAG_W = 4;
  localparam int PIPE_MIN  = 1;
  localparam int PIPE_MAX  = 3;
  localparam int GP_W      = 2;

  // Generate/propagate pair for a span of bits or groups.
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Combine a more-significant span (hi) with the adjacent less-significant
  // span (lo): hi generates, or hi propagates what lo generates.
  function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  function automatic logic is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/pipelined_prefix_adder_if.sv
// Operation/result bus of the pipelined prefix adder.
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high; once valid is raised the producer holds valid and payload
// stable until that transfer; ready may depend combinationally on the far side.
//  in_valid/in_ready   operation handshake (producer -> adder)
//  in_a, in_b          operands
//  in_cin, in_sub      carry in (add only), subtract select
//  in_tag              opaque sideband tag
//  out_valid/out_ready result handshake (adder -> consumer)
//  out_sum, out_cout   result and carry out (sub: 1 = no borrow)
//  out_ovf, out_tag    signed overflow and the tag of this result
// Modports: master = operation producer / result consumer, slave = adder.
interface pipelined_prefix_adder_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
  );
endinterface

// File: rtl/pipelined_prefix_adder_slice.sv
// prefix_pipe_slice: one valid/ready register slice of width W.
//  clk, rst_n              clock, asynchronous active-low reset
//  in_valid/in_ready       upstream handshake, in_data payload
//  out_valid/out_ready     downstream handshake, out_data payload
// The slice loads whenever it is empty or its content is leaving this
// cycle, so a chain of slices sustains one transfer per cycle; ready
// therefore ripples combinationally back from the last slice.
module prefix_pipe_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         valid_q;
  logic [W-1:0] data_q;

  assign in_ready = !valid_q || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      // Payload only moves with a real operation; bubbles leave it as is.
      if (in_valid) data_q <= in_data;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
endmodule

// File: rtl/pipelined_prefix_adder.sv
// pipelined_prefix_adder: grouped Brent-Kung adder/subtractor with a
// valid/ready pipeline of PIPE_STAGES register slices (latency = PIPE_STAGES).
//  clk    rising-edge clock
//  rst_n  asynchronous active-low reset; drops all in-flight operations
//  bus    slave side of pipelined_prefix_adder_if (operation in, result out)
// Datapath: group g/p -> prefix tree up-sweep -> down-sweep + sums.
// Slice placement: 1 = output only; 2 = also between up- and down-sweep;
// 3 = also after group g/p.
// Build option: define ADDER_SAT_EN to saturate out_sum on signed overflow
// (out_ovf and the unsaturated out_cout are still reported).
module pipelined_prefix_adder
  import pipelined_prefix_adder_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int GROUP       = DEF_GROUP,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = DEF_TAG_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pipelined_prefix_adder_if.slave bus
);
  localparam int NG    = WIDTH / GROUP;
  localparam int LG    = $clog2(NG);
  localparam int MID_W = TAG_W + 1 + GP_W * NG + 2 * WIDTH;
  localparam int OUT_W = TAG_W + 2 + WIDTH;

  if (PIPE_STAGES < PIPE_MIN || PIPE_STAGES > PIPE_MAX) begin : g_bad_pipe
    $error("pipelined_prefix_adder: PIPE_STAGES must be 1..3");
  end
  if ((WIDTH % GROUP) != 0 || !is_pow2(WIDTH / GROUP) || (WIDTH / GROUP) < 4) begin : g_bad_ratio
    $error("pipelined_prefix_adder: WIDTH/GROUP must be an integer power of two >= 4");
  end

  // ---------------- operand conditioning and group g/p ----------------
  logic [WIDTH-1:0] s1_bx;
  logic             s1_c0;
  gp_t [NG-1:0]     s1_gp;
  gp_t              bit_gp;
  gp_t              acc_gp;

  always_comb begin
    s1_bx  = bus.in_sub ? ~bus.in_b : bus.in_b;
    // Subtraction is A + ~B + 1, so the caller's carry is ignored there.
    s1_c0  = bus.in_sub | bus.in_cin;
    s1_gp  = '0;
    bit_gp = '0;
    acc_gp = '0;
    for (int k = 0; k < NG; k++) begin
      acc_gp = '{g: 1'b0, p: 1'b1};
      for (int j = 0; j < GROUP; j++) begin
        bit_gp.g = bus.in_a[k*GROUP+j] & s1_bx[k*GROUP+j];
        bit_gp.p = bus.in_a[k*GROUP+j] ^ s1_bx[k*GROUP+j];
        acc_gp   = gp_combine(bit_gp, acc_gp);
      end
      s1_gp[k] = acc_gp;
    end
  end

  logic [MID_W-1:0] d1_d, d1_q, d2_d, d2_q;
  logic             v1, r1, v2, r2, first_ready;

  assign d1_d = {bus.in_tag, s1_c0, s1_gp, s1_bx, bus.in_a};

  if (PIPE_STAGES == 3) begin : g_gp_slice
    prefix_pipe_slice #(.W(MID_W)) u_gp_slice (
      .clk(clk), .rst_n(rst_n),
      .in_valid(bus.in_valid), .in_ready(first_ready), .in_data(d1_d),
      .out_valid(v1), .out_ready(r1), .out_data(d1_q)
    );
  end else begin : g_gp_pass
    assign v1          = bus.in_valid;
    assign first_ready = r1;
    assign d1_q        = d1_d;
  end

  // ---------------- prefix tree, first half (up-sweep) ----------------
  logic [WIDTH-1:0] m1_a, m1_bx;
  logic             m1_c0;
  logic [TAG_W-1:0] m1_tag;
  gp_t [NG-1:0]     m1_gp, m1_up;

  assign {m1_tag, m1_c0, m1_gp, m1_bx, m1_a} = d1_q;

  always_comb begin
    m1_up = m1_gp;
    // Node i of level l spans the 2^(l+1) groups ending at i.
    for (int l = 0; l < LG; l++) begin
      for (int i = (2 << l) - 1; i < NG; i += (2 << l)) begin
        m1_up[i] = gp_combine(m1_up[i], m1_up[i - (1 << l)]);
      end
    end
  end

  assign d2_d = {m1_tag, m1_c0, m1_up, m1_bx, m1_a};

  if (PIPE_STAGES >= 2) begin : g_mid_slice
    prefix_pipe_slice #(.W(MID_W)) u_mid_slice (
      .clk(clk), .rst_n(rst_n),
      .in_valid(v1), .in_ready(r1), .in_data(d2_d),
      .out_valid(v2), .out_ready(r2), .out_data(d2_q)
    );
  end else begin : g_mid_pass
    assign v2   = v1;
    assign r1   = r2;
    assign d2_q = d2_d;
  end

  // ------------- prefix tree, second half (down-sweep) + sums ---------
  logic [WIDTH-1:0] m2_a, m2_bx, sum_raw, sum_fin;
  logic             m2_c0, cout, ovf, c;
  logic [TAG_W-1:0] m2_tag;
  gp_t [NG-1:0]     m2_up, m2_pre;
  logic [NG:0]      gcin;

  assign {m2_tag, m2_c0, m2_up, m2_bx, m2_a} = d2_q;

  always_comb begin
    m2_pre = m2_up;
    // Fill the prefixes the up-sweep skipped, coarsest level first.
    for (int l = LG - 2; l >= 0; l--) begin
      for (int i = 3 * (1 << l) - 1; i < NG; i += (2 << l)) begin
        m2_pre[i] = gp_combine(m2_pre[i], m2_pre[i - (1 << l)]);
      end
    end
  end

  always_comb begin
    gcin    = '0;
    sum_raw = '0;
    c       = 1'b0;
    gcin[0] = m2_c0;
    // m2_pre[k] spans groups 0..k, so it yields the carry into group k+1.
    for (int k = 0; k < NG; k++) begin
      gcin[k+1] = m2_pre[k].g | (m2_pre[k].p & m2_c0);
    end
    // Short ripple inside each group, seeded by that group's carry.
    for (int i = 0; i < WIDTH; i++) begin
      if ((i % GROUP) == 0) c = gcin[i / GROUP];
      sum_raw[i] = m2_a[i] ^ m2_bx[i] ^ c;
      c = (m2_a[i] & m2_bx[i]) | ((m2_a[i] ^ m2_bx[i]) & c);
    end
    cout = gcin[NG];
    ovf  = (m2_a[WIDTH-1] == m2_bx[WIDTH-1]) && (sum_raw[WIDTH-1] != m2_a[WIDTH-1]);
  end

`ifdef ADDER_SAT_EN
  // Overflow can only happen with equal operand signs; A's sign picks the rail.
  always_comb begin
    sum_fin = sum_raw;
    if (ovf) sum_fin = m2_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign sum_fin = sum_raw;
`endif

  // ---------------- output slice ----------------
  logic [OUT_W-1:0] o_d, o_q;

  assign o_d = {m2_tag, ovf, cout, sum_fin};

  prefix_pipe_slice #(.W(OUT_W)) u_out_slice (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v2), .in_ready(r2), .in_data(o_d),
    .out_valid(bus.out_valid), .out_ready(bus.out_ready), .out_data(o_q)
  );

  assign {bus.out_tag, bus.out_ovf, bus.out_cout, bus.out_sum} = o_q;

  // Refuse operations while reset is asserted; they would be lost anyway.
  assign bus.in_ready = rst_n & first_ready;

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Bench for pipelined_prefix_adder: directed corner operations, latency,
// stall/backpressure, reset with operations in flight, and random traffic.
// PS selects the pipeline depth; define ADDER_SAT_EN to match a saturating build.
module tb_pipelined_prefix_adder;
  parameter int PS = 2;
  localparam int W  = 32;
  localparam int G  = 4;
  localparam int TW = 4;
  localparam int EW = TW + 2 + W;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_prefix_adder_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  pipelined_prefix_adder #(.WIDTH(W), .GROUP(G), .PIPE_STAGES(PS), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] cur_exp;
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  // Behavioural reference: plain wide addition, no prefix structure.
  function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sub,
                                          input logic [TW-1:0] tag);
    logic [W-1:0] bx;
    logic [W:0]   full;
    logic [W-1:0] sum;
    logic         ovf;
    bx   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    sum  = full[W-1:0];
    ovf  = (a[W-1] == bx[W-1]) && (sum[W-1] != a[W-1]);
`ifdef ADDER_SAT_EN
    if (ovf) sum = a[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return {tag, ovf, full[W], sum};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input logic [TW-1:0] tag);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_sub   = sub;
    bus.in_tag   = tag;
    bus.in_valid = 1'b1;
    cur_exp      = model(a, b, cin, sub, tag);
  endtask

  // One clock: sample handshakes at the falling edge, retire/record, then
  // return 1 time unit after the rising edge where the transfers happen.
  task automatic cycle_step(output bit acc);
    logic [EW-1:0] got;
    logic [EW-1:0] expv;
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      got = {bus.out_tag, bus.out_ovf, bus.out_cout, bus.out_sum};
      check("result_expected", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        expv = exp_q.pop_front();
        check("result", 64'(got), 64'(expv));
      end
    end
    if (acc) exp_q.push_back(cur_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input logic [TW-1:0] tag,
                          input logic [W-1:0] e_sum, input logic e_cout, input logic e_ovf);
    bit acc;
    int n;
    set_op(a, b, cin, sub, tag);
    cur_exp = {tag, e_ovf, e_cout, e_sum};
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      cycle_step(acc);
      n++;
    end
    check("accept_in_time", 64'(acc), 64'(1));
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      cycle_step(acc);
      n++;
    end
    check("drain_done", 64'(exp_q.size()), 64'(0));
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] corners [6];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h7FFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h0000_0001;
    corners[5] = 32'h0F0F_F0F0;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  // Independent watchdog so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bit acc;
    int lat;
    int idx;
    int n_ops;
    int cyc;
    int n_flight;
    bit stalling;
    bit resumed;
    logic [EW-1:0] snap;

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.in_sub    = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    cur_exp       = '0;

    // Reset state.
    #3;
    check("reset_in_ready", 64'(bus.in_ready), 64'(0));
    check("reset_out_valid", 64'(bus.out_valid), 64'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cycle_step(acc);
    check("post_reset_in_ready", 64'(bus.in_ready), 64'(1));
    check("post_reset_out_valid", 64'(bus.out_valid), 64'(0));

    // 1. Wrap to zero with carry out, and result latency.
    drive_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 4'h1, 32'h0, 1'b1, 1'b0);
    lat = 0;
    while (!bus.out_valid && lat < 10) begin
      cycle_step(acc);
      lat++;
    end
    check("latency", 64'(lat), 64'(PS - 1));
    drain();

    // 2. Subtraction with and without borrow; carry in in both modes.
    drive_op(32'd5, 32'd7, 1'b0, 1'b1, 4'h2, 32'hFFFF_FFFE, 1'b0, 1'b0);
    drive_op(32'd7, 32'd5, 1'b0, 1'b1, 4'h3, 32'h2, 1'b1, 1'b0);
    drive_op(32'd1, 32'd2, 1'b1, 1'b0, 4'h4, 32'h4, 1'b0, 1'b0);
    drive_op(32'd10, 32'd3, 1'b1, 1'b1, 4'h5, 32'h7, 1'b1, 1'b0);
    drain();

    // 3. Signed overflow in both directions.
`ifdef ADDER_SAT_EN
    drive_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 4'h6, 32'h7FFF_FFFF, 1'b0, 1'b1);
    drive_op(32'h8000_0000, 32'h1, 1'b0, 1'b1, 4'h7, 32'h8000_0000, 1'b1, 1'b1);
`else
    drive_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 4'h6, 32'h8000_0000, 1'b0, 1'b1);
    drive_op(32'h8000_0000, 32'h1, 1'b0, 1'b1, 4'h7, 32'h7FFF_FFFF, 1'b1, 1'b1);
`endif
    drain();

    // 4. Eight back-to-back operations with a 5-cycle stall mid-stream.
    bus.out_ready = 1'b1;
    idx      = 0;
    stalling = 1'b0;
    resumed  = 1'b0;
    snap     = '0;
    set_op(32'h1111_0000, 32'h0000_2222, 1'b0, 1'b0, 4'(idx));
    for (int c = 0; c < 60; c++) begin
      if (idx >= 8 && exp_q.size() == 0) break;
      if (c == 4) begin
        check("stall_start_valid", 64'(bus.out_valid), 64'(1));
        snap = {bus.out_tag, bus.out_ovf, bus.out_cout, bus.out_sum};
        bus.out_ready = 1'b0;
        stalling = 1'b1;
      end
      if (c == 9) begin
        check("full_in_ready", 64'(bus.in_ready), 64'(0));
        check("held_ops", 64'(exp_q.size()), 64'(PS));
        bus.out_ready = 1'b1;
        stalling = 1'b0;
        resumed  = 1'b1;
      end
      if (resumed && exp_q.size() > 0) check("no_gap", 64'(bus.out_valid), 64'(1));
      cycle_step(acc);
      if (stalling)
        check("stall_hold", 64'({bus.out_valid, bus.out_tag, bus.out_ovf, bus.out_cout, bus.out_sum}),
              64'({1'b1, snap}));
      if (acc) begin
        idx++;
        if (idx < 8) set_op(32'h1111_0000 * idx + 32'(idx), 32'hF000_0001 + 32'(idx * 3),
                            1'(idx & 1), 1'(idx >> 1 & 1), 4'(idx));
        else bus.in_valid = 1'b0;
      end
    end
    check("stream_ops_issued", 64'(idx), 64'(8));
    drain();

    // 5. Reset with operations in flight: they must vanish.
    bus.out_ready = 1'b0;
    n_flight = (PS >= 2) ? 2 : 1;
    for (int k = 0; k < n_flight; k++) begin
      drive_op(32'h1234_5678, 32'h0101_0101 + 32'(k), 1'b0, 1'b0, 4'(9 + k),
               32'h1335_5779 + 32'(k), 1'b0, 1'b0);
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", 64'(bus.out_valid), 64'(0));
    check("async_reset_in_ready", 64'(bus.in_ready), 64'(0));
    check("async_reset_payload", 64'({bus.out_tag, bus.out_sum}), 64'(0));
    exp_q.delete();
    cycle_step(acc);
    cycle_step(acc);
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    cycle_step(acc);
    check("release_in_ready", 64'(bus.in_ready), 64'(1));
    for (int k = 0; k < 8; k++) begin
      cycle_step(acc);
      check("no_ghost_output", 64'(bus.out_valid), 64'(0));
    end

    // 6. Random traffic with random backpressure.
    n_ops = 0;
    cyc   = 0;
    while (n_ops < 10000 && cyc < 60000) begin
      if (!bus.in_valid && $urandom_range(0, 3) != 0)
        set_op(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), n_ops[TW-1:0]);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle_step(acc);
      if (acc) begin
        n_ops++;
        bus.in_valid = 1'b0;
      end
      cyc++;
    end
    check("random_ops_issued", 64'(n_ops), 64'(10000));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
